capture_ctrl: RTL and testbench

Capture sequencer for the logic analyzer's 8K×8 sample buffer. It arms on command and writes incoming samples into the buffer as a circular pre-trigger history. It then detects a masked trigger pattern, fills the remaining post-trigger depth and stops. Finally, it streams the 8192 captured bytes out, oldest first, to the host interface over a valid/ready handshake. It is the only master of the buffer's EN/WE/ADDR/DIN pins.

---
 rtl/capture_ctrl_if.sv | 29 ++
 rtl/capture_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_capture_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/capture_ctrl_if.sv
// Buffer port and readout stream bundle driven by capture_ctrl.
interface capture_ctrl_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;

  modport master (
    output ram_en, ram_we, ram_addr, ram_din,
    input  ram_dout,
    output rd_data, rd_valid, rd_last,
    input  rd_ready
  );

  modport slave (
    input  ram_en, ram_we, ram_addr, ram_din,
    output ram_dout,
    input  rd_data, rd_valid, rd_last,
    output rd_ready
  );
endinterface

// File: rtl/capture_ctrl.sv
// Logic-analyzer capture sequencer: pre-trigger history, trigger, post fill, readout.
// Define CAPTURE_DECIM_EN to add the decim_i sample decimation input.
module capture_ctrl #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] pretrig_i,
  input  logic [DATA_W-1:0] trig_val_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_stb_i,
  input  logic              rd_start_i,
`ifdef CAPTURE_DECIM_EN
  input  logic [7:0]        decim_i,
`endif
  capture_ctrl_if.master    bus,
  output logic              busy_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] trig_addr_o
);

  typedef enum logic [2:0] {
    IDLE, PREFILL, WAIT_TRIG, POST,
    DONE, RD_ISSUE, RD_WAIT, RD_HOLD
  } state_t;

  localparam logic [ADDR_W-1:0] ONE_A = 1;
  localparam logic [ADDR_W-1:0] PMAX  = '1;
  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   REM1  = 1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   pre_q, pre_d;
  logic [ADDR_W-1:0]   taddr_q, taddr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic                trig_q, trig_d;
  logic [DATA_W-1:0]   rdat_q, rdat_d;
  logic                rval_q, rval_d;
  logic                rlast_q, rlast_d;
  logic                busy_q, done_q;
  logic                cap, acc, match, stb_ok;
`ifdef CAPTURE_DECIM_EN
  logic [7:0]          dec_q, dec_d;
`endif

  always_comb begin
    cap = (state_q == PREFILL) || (state_q == WAIT_TRIG)
       || (state_q == POST);
`ifdef CAPTURE_DECIM_EN
    stb_ok = (dec_q == 8'd0);
`else
    stb_ok = 1'b1;
`endif
    acc   = cap && sample_stb_i && stb_ok;
    match = ((sample_i ^ trig_val_i) & trig_mask_i) == '0;
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    pre_d    = pre_q;
    taddr_d  = taddr_q;
    rem_d    = rem_q;
    trig_d   = trig_q;
    rdat_d   = rdat_q;
    rval_d   = rval_q;
    rlast_d  = rlast_q;
`ifdef CAPTURE_DECIM_EN
    dec_d    = dec_q;
`endif
    bus.ram_en   = 1'b0;
    bus.ram_we   = 1'b0;
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    // Abort wins over everything, including a same-cycle write.
    if (abort_i) begin
      state_d = IDLE;
      rval_d  = 1'b0;
      rlast_d = 1'b0;
    end else begin
      if (acc) begin
        bus.ram_en   = 1'b1;
        bus.ram_we   = 1'b1;
        bus.ram_addr = wr_ptr_q;
        bus.ram_din  = sample_i;
        wr_ptr_d     = wr_ptr_q + ONE_A;
      end
`ifdef CAPTURE_DECIM_EN
      if (cap && sample_stb_i)
        dec_d = (dec_q == decim_i) ? 8'd0 : dec_q + 8'd1;
`endif
      unique case (state_q)
        IDLE: if (arm_i) begin
          wr_ptr_d = '0;
          cnt_d    = '0;
          trig_d   = 1'b0;
          pre_d    = pretrig_i;
`ifdef CAPTURE_DECIM_EN
          dec_d    = 8'd0;
`endif
          state_d  = (pretrig_i == '0) ? WAIT_TRIG : PREFILL;
        end
        PREFILL: if (acc) begin
          cnt_d = cnt_q + ONE_A;
          if (cnt_q + ONE_A == pre_q) state_d = WAIT_TRIG;
        end
        WAIT_TRIG: if (acc && match) begin
          taddr_d = wr_ptr_q;
          trig_d  = 1'b1;
          cnt_d   = PMAX - pre_q;
          state_d = (pre_q == PMAX) ? DONE : POST;
        end
        POST: if (acc) begin
          cnt_d = cnt_q - ONE_A;
          if (cnt_q == ONE_A) state_d = DONE;
        end
        DONE: if (rd_start_i) begin
          rd_ptr_d = wr_ptr_q;
          rem_d    = DEPTH;
          state_d  = RD_ISSUE;
        end
        RD_ISSUE: begin
          bus.ram_en   = 1'b1;
          bus.ram_addr = rd_ptr_q;
          state_d      = RD_WAIT;
        end
        RD_WAIT: begin
          rdat_d   = bus.ram_dout;
          rval_d   = 1'b1;
          rlast_d  = (rem_q == REM1);
          rd_ptr_d = rd_ptr_q + ONE_A;
          state_d  = RD_HOLD;
        end
        RD_HOLD: if (bus.rd_ready) begin
          rval_d  = 1'b0;
          rlast_d = 1'b0;
          rem_d   = rem_q - REM1;
          state_d = (rem_q == REM1) ? IDLE : RD_ISSUE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      pre_q    <= '0;
      taddr_q  <= '0;
      rem_q    <= '0;
      trig_q   <= 1'b0;
      rdat_q   <= '0;
      rval_q   <= 1'b0;
      rlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef CAPTURE_DECIM_EN
      dec_q    <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      pre_q    <= pre_d;
      taddr_q  <= taddr_d;
      rem_q    <= rem_d;
      trig_q   <= trig_d;
      rdat_q   <= rdat_d;
      rval_q   <= rval_d;
      rlast_q  <= rlast_d;
      busy_q   <= (state_d != IDLE) && (state_d != DONE);
      done_q   <= (state_d == DONE);
`ifdef CAPTURE_DECIM_EN
      dec_q    <= dec_d;
`endif
    end
  end

  assign bus.rd_data  = rdat_q;
  assign bus.rd_valid = rval_q;
  assign bus.rd_last  = rlast_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign triggered_o  = trig_q;
  assign trig_addr_o  = taddr_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with an 8Kx8 buffer model.
module tb_capture_ctrl;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int DEPTH = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm_i, abort_i, sample_stb, rd_start;
  logic [AW-1:0] pretrig;
  logic [DW-1:0] trig_val, trig_mask, sample_in;
  logic          busy_o, triggered_o, done_o;
  logic [AW-1:0] trig_addr_o;
`ifdef CAPTURE_DECIM_EN
  logic [7:0]    decim;
`endif

  capture_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .arm_i       (arm_i),
    .abort_i     (abort_i),
    .pretrig_i   (pretrig),
    .trig_val_i  (trig_val),
    .trig_mask_i (trig_mask),
    .sample_i    (sample_in),
    .sample_stb_i(sample_stb),
    .rd_start_i  (rd_start),
`ifdef CAPTURE_DECIM_EN
    .decim_i     (decim),
`endif
    .bus         (bus),
    .busy_o      (busy_o),
    .triggered_o (triggered_o),
    .done_o      (done_o),
    .trig_addr_o (trig_addr_o)
  );

  always #5 clk = ~clk;

  logic [7:0]    mem [DEPTH];
  int            wr_cnt;
  logic [AW-1:0] last_wa;
  logic          wc_clr;

  always @(posedge clk) begin
    if (wc_clr) wr_cnt <= 0;
    if (bus.ram_en) begin
      if (bus.ram_we) begin
        mem[bus.ram_addr] <= bus.ram_din;
        wr_cnt  <= wr_cnt + 1;
        last_wa <= bus.ram_addr;
      end else begin
        bus.ram_dout <= mem[bus.ram_addr];
      end
    end
  end

  int checks = 0;
  int errs   = 0;
  logic [7:0] rb [DEPTH];
  int lastidx;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic arm(input logic [AW-1:0] p, input logic [7:0] tv,
                     input logic [7:0] tm);
    @(negedge clk);
    pretrig = p; trig_val = tv; trig_mask = tm;
    arm_i = 1'b1; wc_clr = 1'b1;
    @(negedge clk);
    arm_i = 1'b0; wc_clr = 1'b0;
  endtask

  task automatic capture(output int n);
    n = 0;
    for (int c = 0; c < 20000; c++) begin
      if (done_o) break;
      sample_stb = 1'b1;
      sample_in  = n[7:0];
      n++;
      @(negedge clk);
    end
    sample_stb = 1'b0;
  endtask

  task automatic readout(input int maxb, output int nb, output int nl);
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    bus.rd_ready = 1'b1;
    nb = 0; nl = 0; lastidx = -1;
    for (int c = 0; c < 30000; c++) begin
      if (nb >= maxb) break;
      if (bus.rd_valid) begin
        rb[nb] = bus.rd_data;
        if (bus.rd_last) begin nl++; lastidx = nb; end
        nb++;
      end else if (!busy_o) begin
        break;
      end
      @(negedge clk);
    end
    bus.rd_ready = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] pre;
    logic [7:0]    tv, tm;
    logic [AW-1:0] taddr;
    int            writes;
    logic [AW-1:0] lastwa;
    logic [7:0]    first, tbyte, last;
    logic          full;
  } vec_t;

  vec_t v [4];

  initial begin
    int n, nb, nl, bad;
    logic [AW-1:0] a;
    v[0] = '{13'd16, 8'h64, 8'hFF, 13'd100, 8276, 13'd83,
             8'h54, 8'h64, 8'h53, 1'b1};
    v[1] = '{13'd0,  8'h00, 8'h00, 13'd0,   8192, 13'd8191,
             8'h00, 8'h00, 8'hFF, 1'b0};
    v[2] = '{13'd32, 8'h05, 8'hFF, 13'd261, 8421, 13'd228,
             8'hE5, 8'h05, 8'hE4, 1'b0};
    v[3] = '{13'd16, 8'h35, 8'hF0, 13'd48,  8224, 13'd31,
             8'h20, 8'h30, 8'h1F, 1'b0};

    rst = 1'b1; arm_i = 0; abort_i = 0; sample_stb = 0; rd_start = 0;
    pretrig = '0; trig_val = '0; trig_mask = '0; sample_in = '0;
    bus.rd_ready = 1'b0; wc_clr = 1'b1;
`ifdef CAPTURE_DECIM_EN
    decim = 8'd0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0; wc_clr = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_trig", triggered_o, 0);
    chk("rst_taddr", trig_addr_o, 0);
    chk("rst_rd", {bus.rd_valid, bus.rd_last, bus.rd_data}, 0);
    chk("rst_ram", {bus.ram_en, bus.ram_we, bus.ram_addr}, 0);

    for (int i = 0; i < 4; i++) begin
      arm(v[i].pre, v[i].tv, v[i].tm);
      chk($sformatf("v%0d_busy_arm", i), busy_o, 1);
      chk($sformatf("v%0d_trig_arm", i), triggered_o, 0);
      capture(n);
      chk($sformatf("v%0d_done", i), {done_o, busy_o}, 2'b10);
      chk($sformatf("v%0d_triggered", i), triggered_o, 1);
      chk($sformatf("v%0d_taddr", i), trig_addr_o, v[i].taddr);
      chk($sformatf("v%0d_writes", i), wr_cnt, v[i].writes);
      chk($sformatf("v%0d_lastwa", i), last_wa, v[i].lastwa);
      readout(v[i].full ? DEPTH : int'(v[i].pre) + 1, nb, nl);
      chk($sformatf("v%0d_first", i), rb[0], v[i].first);
      chk($sformatf("v%0d_tbyte", i), rb[v[i].pre], v[i].tbyte);
      if (v[i].full) begin
        chk($sformatf("v%0d_nbytes", i), nb, DEPTH);
        chk($sformatf("v%0d_nlast", i), nl, 1);
        chk($sformatf("v%0d_lastidx", i), lastidx, DEPTH - 1);
        chk($sformatf("v%0d_lastbyte", i), rb[DEPTH-1], v[i].last);
        bad = 0;
        for (int k = 0; k < DEPTH; k++) begin
          a = v[i].taddr - v[i].pre + k[AW-1:0];
          if (rb[k] !== mem[a]) bad++;
        end
        chk($sformatf("v%0d_seq", i), bad, 0);
        chk($sformatf("v%0d_idle", i), {busy_o, done_o}, 0);
      end else begin
        chk($sformatf("v%0d_nbytes", i), nb, int'(v[i].pre) + 1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk($sformatf("v%0d_abort_rd", i),
            {bus.rd_valid, busy_o, done_o}, 0);
      end
    end

    // Abort in POST together with a strobe
    arm(13'd0, 8'h00, 8'h00);
    sample_stb = 1'b1; sample_in = 8'h11;
    @(negedge clk);
    sample_stb = 1'b0;
    chk("ab_trig", {triggered_o, busy_o, done_o}, 3'b110);
    chk("ab_taddr0", trig_addr_o, 0);
    arm_i = 1'b1;
    @(negedge clk);
    arm_i = 1'b0;
    chk("ab_arm_ignored", triggered_o, 1);
    sample_stb = 1'b1; sample_in = 8'h22; abort_i = 1'b1;
    #1;
    chk("ab_no_write", bus.ram_en, 0);
    @(negedge clk);
    sample_stb = 1'b0; abort_i = 1'b0;
    chk("ab_idle", {busy_o, done_o, bus.ram_en}, 0);
    chk("ab_writes", wr_cnt, 1);
    chk("ab_taddr_kept", trig_addr_o, 0);
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    chk("rdstart_ignored", {busy_o, bus.ram_en}, 0);

    // PRETRIG max: trigger completes capture directly, then stall readout
    arm(13'd8191, 8'h00, 8'h00);
    capture(n);
    chk("pmax_done", {done_o, busy_o}, 2'b10);
    chk("pmax_taddr", trig_addr_o, 8191);
    chk("pmax_writes", wr_cnt, 8192);
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    chk("iss_ram", {bus.ram_en, bus.ram_we, bus.ram_addr}, {2'b10, 13'd0});
    chk("iss_valid", bus.rd_valid, 0);
    @(negedge clk);
    chk("wait_valid", {bus.rd_valid, bus.ram_en}, 0);
    @(negedge clk);
    chk("hold_valid", bus.rd_valid, 1);
    chk("hold_data", bus.rd_data, 8'h00);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h00 ||
          bus.ram_en !== 1'b0) bad++;
    end
    chk("stall_stable", bad, 0);
    bus.rd_ready = 1'b1;
    @(negedge clk);
    bus.rd_ready = 1'b0;
    chk("accept_drop", bus.rd_valid, 0);
    for (int k = 0; k < 5; k++) begin
      if (bus.rd_valid) break;
      @(negedge clk);
    end
    chk("next_valid", bus.rd_valid, 1);
    chk("next_data", bus.rd_data, 8'h01);
    chk("next_notlast", bus.rd_last, 0);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("rd_abort", {bus.rd_valid, busy_o, done_o}, 0);

`ifdef CAPTURE_DECIM_EN
    decim = 8'd3;
    arm(13'd0, 8'hFF, 8'hFF);
    for (int k = 0; k < 12; k++) begin
      sample_stb = 1'b1; sample_in = k[7:0];
      @(negedge clk);
    end
    sample_stb = 1'b0;
    chk("dec_writes", wr_cnt, 3);
    chk("dec_m0", mem[0], 8'd0);
    chk("dec_m1", mem[1], 8'd4);
    chk("dec_m2", mem[2], 8'd8);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    decim = 8'd0;
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
